// File: rtl/router_pkt_tx_pkg.sv
// Shared types and header layout for the router packet transmitter.
package router_tx_pkg;

  // Transmitter sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_PARITY  = 3'd3,
    ST_GAP     = 3'd4
  } tx_state_e;

  // Header byte layout: length in the upper six bits, destination in the lower two.
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = 2;
  localparam int LEN_LSB  = 2;
  localparam int LEN_W    = 6;
  localparam int MAX_LEN  = 63;

  // Pack destination and length into a header byte.
  function automatic logic [7:0] make_header(input logic [ADDR_W-1:0] addr,
                                             input logic [LEN_W-1:0]  len);
    logic [7:0] hdr;
    hdr = 8'h00;
    hdr[ADDR_LSB +: ADDR_W] = addr;
    hdr[LEN_LSB +: LEN_W]   = len;
    return hdr;
  endfunction

  // Final parity byte, optionally corrupted for negative testing of the router.
  function automatic logic [7:0] parity_out(input logic [7:0] acc, input logic invert);
    return invert ? ~acc : acc;
  endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Router input-side bus: byte stream with valid, plus busy/error feedback.
interface router_pkt_tx_if;
  logic       packet_valid;
  logic [7:0] data;
  logic       busy;
  logic       err;

  modport master (output packet_valid, output data, input busy, input err);
  modport slave  (input packet_valid, input data, output busy, output err);
endinterface

// File: rtl/router_pkt_tx_fifo.sv
// Payload byte buffer: first-word-fall-through, writes while full are dropped.
module router_tx_fifo #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             rd_en,
  output logic [7:0]       rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam int PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  logic [7:0]       mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             wr_ok_s;
  logic             rd_ok_s;

  // Pointer advance with wrap, so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  // Fullness is judged before this cycle's pop, so a full-buffer write is lost.
  assign full    = (count_r == CNT_W'(DEPTH));
  assign wr_ok_s = wr_en && !full;
  assign rd_ok_s = rd_en && (count_r != {CNT_W{1'b0}});
  assign rd_data = mem_r[rd_ptr_r];
  assign count   = count_r;

  // Byte storage; contents need no reset since count gates every read.
  always_ff @(posedge clock) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (rd_ok_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet source: header, buffered payload, parity byte, then an idle gap.
module router_pkt_tx
  import router_tx_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int GAP   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pay_wr_en,
  input  logic [7:0]        pay_data,
  output logic              pay_full,
  output logic [6:0]        pay_count,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              req_bad_parity,
  output logic              req_ready,
  router_pkt_tx_if.master   rtr,
  output logic              tx_done,
  output logic              err_seen
);

  localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP + 1);

  tx_state_e        state_r;
  logic [LEN_W-1:0] len_r;
  logic             bad_r;
  logic [LEN_W-1:0] remaining_r;
  logic [GAP_W-1:0] gap_r;
  logic [7:0]       acc_r;
  logic             pv_r;
  logic [7:0]       data_r;
  logic             tx_done_r;
  logic             err_seen_r;

  logic             accept_s;
  logic             pop_s;
  logic [7:0]       fifo_dout_s;
  logic [6:0]       pay_count_s;
  logic             pay_full_s;

  router_tx_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (7)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (pay_wr_en),
    .wr_data (pay_data),
    .rd_en   (pop_s),
    .rd_data (fifo_dout_s),
    .count   (pay_count_s),
    .full    (pay_full_s)
  );

  // A request is only taken once its whole payload is already buffered.
  assign req_ready = (state_r == ST_IDLE) && (pay_count_s >= {1'b0, req_len});
  assign accept_s  = req_valid && req_ready;

  // Pop the buffer head whenever the next displayed byte is payload.
  always_comb begin
    pop_s = 1'b0;
    if (!rtr.busy) begin
      case (state_r)
        ST_HEADER:  pop_s = (len_r != {LEN_W{1'b0}});
        ST_PAYLOAD: pop_s = (remaining_r > LEN_W'(1));
        default:    pop_s = 1'b0;
      endcase
    end else begin
      pop_s = 1'b0;
    end
  end

  // Packet sequencer with registered bus outputs; busy freezes every byte state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      len_r       <= {LEN_W{1'b0}};
      bad_r       <= 1'b0;
      remaining_r <= {LEN_W{1'b0}};
      gap_r       <= {GAP_W{1'b0}};
      acc_r       <= 8'h00;
      pv_r        <= 1'b0;
      data_r      <= 8'h00;
      tx_done_r   <= 1'b0;
    end else begin
      tx_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            len_r   <= req_len;
            bad_r   <= req_bad_parity;
            data_r  <= make_header(req_addr, req_len);
            acc_r   <= make_header(req_addr, req_len);
            pv_r    <= 1'b1;
            state_r <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          if (!rtr.busy) begin
            if (len_r != {LEN_W{1'b0}}) begin
              data_r      <= fifo_dout_s;
              acc_r       <= acc_r ^ fifo_dout_s;
              remaining_r <= len_r;
              state_r     <= ST_PAYLOAD;
            end else begin
              data_r  <= parity_out(acc_r, bad_r);
              pv_r    <= 1'b0;
              state_r <= ST_PARITY;
            end
          end
        end
        ST_PAYLOAD: begin
          if (!rtr.busy) begin
            if (remaining_r > LEN_W'(1)) begin
              data_r      <= fifo_dout_s;
              acc_r       <= acc_r ^ fifo_dout_s;
              remaining_r <= remaining_r - LEN_W'(1);
            end else begin
              // Last payload byte was already folded into acc_r when popped.
              data_r  <= parity_out(acc_r, bad_r);
              pv_r    <= 1'b0;
              state_r <= ST_PARITY;
            end
          end
        end
        ST_PARITY: begin
          if (!rtr.busy) begin
            data_r    <= 8'h00;
            tx_done_r <= 1'b1;
            if (GAP == 0) begin
              state_r <= ST_IDLE;
            end else begin
              gap_r   <= GAP_W'(GAP);
              state_r <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_r <= GAP_W'(1)) begin
            state_r <= ST_IDLE;
          end else begin
            gap_r <= gap_r - GAP_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          pv_r    <= 1'b0;
          data_r  <= 8'h00;
        end
      endcase
    end
  end

  // Sticky router error flag; a new error beats the clear from an accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_seen_r <= 1'b0;
    end else if (rtr.err) begin
      err_seen_r <= 1'b1;
    end else if (accept_s) begin
      err_seen_r <= 1'b0;
    end else begin
      err_seen_r <= err_seen_r;
    end
  end

  assign rtr.packet_valid = pv_r;
  assign rtr.data         = data_r;
  assign tx_done          = tx_done_r;
  assign err_seen         = err_seen_r;
  assign pay_count        = pay_count_s;
  assign pay_full         = pay_full_s;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: directed scenarios with literal expectations plus a
// randomized run, all compared each cycle against a queue-based packet model.
module tb_router_pkt_tx;

  localparam int DEPTH = 64;
  localparam int GAP   = 1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pay_wr_en = 1'b0;
  logic [7:0] pay_data = 8'h00;
  logic       pay_full;
  logic [6:0] pay_count;
  logic       req_valid = 1'b0;
  logic [1:0] req_addr = 2'd0;
  logic [5:0] req_len = 6'd0;
  logic       req_bad_parity = 1'b0;
  logic       req_ready;
  logic       tx_done;
  logic       err_seen;

  router_pkt_tx_if rtr_if();

  router_pkt_tx #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .clock          (clock),
    .reset          (reset),
    .pay_wr_en      (pay_wr_en),
    .pay_data       (pay_data),
    .pay_full       (pay_full),
    .pay_count      (pay_count),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_len        (req_len),
    .req_bad_parity (req_bad_parity),
    .req_ready      (req_ready),
    .rtr            (rtr_if),
    .tx_done        (tx_done),
    .err_seen       (err_seen)
  );

  always #5 clock = ~clock;

  // Model: buffered bytes, and the bytes the current packet still has to show.
  typedef struct {
    logic       pv;
    logic [7:0] d;
    bit         pay;
  } item_t;

  item_t      out_q[$];
  logic [7:0] buf_q[$];
  int         cooldown;
  bit         exp_done;
  bit         err_m;
  int         checks;
  int         errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return (out_q.size() == 0) && (cooldown == 0) && (buf_q.size() >= int'(req_len));
  endfunction

  function automatic bit model_idle();
    return (out_q.size() == 0) && (cooldown == 0);
  endfunction

  task automatic model_reset();
    out_q.delete();
    buf_q.delete();
    cooldown = 0;
    exp_done = 1'b0;
    err_m    = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs presented.
  task automatic model_edge();
    bit         rdy;
    bit         acc;
    bit         wr_ok;
    item_t      it;
    logic [7:0] hdr;
    logic [7:0] par;
    rdy   = model_ready();
    acc   = req_valid && rdy;
    wr_ok = pay_wr_en && (buf_q.size() < DEPTH);
    exp_done = 1'b0;
    if (cooldown > 0) cooldown--;
    if (out_q.size() > 0 && !rtr_if.busy) begin
      void'(out_q.pop_front());
      if (out_q.size() == 0) begin
        exp_done = 1'b1;
        cooldown = GAP;
      end else if (out_q[0].pay) begin
        void'(buf_q.pop_front());
      end
    end
    if (acc) begin
      hdr = {req_len, req_addr};
      par = hdr;
      it.pv = 1'b1; it.d = hdr; it.pay = 1'b0;
      out_q.push_back(it);
      for (int i = 0; i < int'(req_len); i++) begin
        par = par ^ buf_q[i];
        it.pv = 1'b1; it.d = buf_q[i]; it.pay = 1'b1;
        out_q.push_back(it);
      end
      it.pv = 1'b0; it.d = req_bad_parity ? ~par : par; it.pay = 1'b0;
      out_q.push_back(it);
    end
    if (wr_ok) buf_q.push_back(pay_data);
    if (rtr_if.err) err_m = 1'b1;
    else if (acc) err_m = 1'b0;
  endtask

  task automatic compare();
    logic       exp_pv;
    logic [7:0] exp_d;
    if (out_q.size() > 0) begin
      exp_pv = out_q[0].pv;
      exp_d  = out_q[0].d;
    end else begin
      exp_pv = 1'b0;
      exp_d  = 8'h00;
    end
    chk("packet_valid", {31'd0, rtr_if.packet_valid}, {31'd0, exp_pv});
    chk("data", {24'd0, rtr_if.data}, {24'd0, exp_d});
    chk("tx_done", {31'd0, tx_done}, {31'd0, exp_done});
    chk("err_seen", {31'd0, err_seen}, {31'd0, err_m});
    chk("pay_count", {25'd0, pay_count}, buf_q.size());
    chk("pay_full", {31'd0, pay_full}, {31'd0, buf_q.size() == DEPTH});
  endtask

  // One clock: check the combinational ready, cross the edge, check outputs.
  task automatic tick();
    #1;
    chk("req_ready", {31'd0, req_ready}, {31'd0, model_ready()});
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare();
  endtask

  task automatic idle_inputs();
    pay_wr_en   = 1'b0;
    req_valid   = 1'b0;
    rtr_if.busy = 1'b0;
    rtr_if.err  = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b);
    pay_wr_en = 1'b1;
    pay_data  = b;
    tick();
    pay_wr_en = 1'b0;
  endtask

  task automatic request(input logic [1:0] a, input logic [5:0] l, input logic bad);
    req_valid      = 1'b1;
    req_addr       = a;
    req_len        = l;
    req_bad_parity = bad;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    for (int i = 0; i < 200 && !model_idle(); i++) tick();
    chk("drain_timeout", {31'd0, model_idle()}, 32'd1);
  endtask

  task automatic pv_data(input string name, input logic [8:0] exp);
    chk(name, {23'd0, rtr_if.packet_valid, rtr_if.data}, {23'd0, exp});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rtr_if.busy = 1'b0;
    rtr_if.err  = 1'b0;
    model_reset();

    // Reset state
    #2;
    pv_data("reset_bus", 9'h000);
    chk("reset_tx_done", {31'd0, tx_done}, 32'd0);
    chk("reset_err_seen", {31'd0, err_seen}, 32'd0);
    chk("reset_count", {25'd0, pay_count}, 32'd0);
    chk("reset_full", {31'd0, pay_full}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Basic 3-byte packet
    write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
    request(2'd1, 6'd3, 1'b0);
    pv_data("basic_hdr", 9'h10D);
    tick(); pv_data("basic_p0", 9'h111);
    tick(); pv_data("basic_p1", 9'h122);
    tick(); pv_data("basic_p2", 9'h133);
    tick(); pv_data("basic_par", 9'h00D);
    tick();
    chk("basic_done", {31'd0, tx_done}, 32'd1);
    chk("basic_count", {25'd0, pay_count}, 32'd0);
    drain();

    // Busy stall on header
    write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
    request(2'd1, 6'd3, 1'b0);
    rtr_if.busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      pv_data("stall_hdr", 9'h10D);
      chk("stall_count", {25'd0, pay_count}, 32'd3);
    end
    rtr_if.busy = 1'b0;
    tick(); pv_data("stall_resume", 9'h111);
    drain();

    // Bad parity, then err_seen set and cleared by the next accept
    write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
    request(2'd1, 6'd3, 1'b1);
    tick(); tick(); tick(); tick();
    pv_data("bad_par", 9'h0F2);
    tick();
    rtr_if.err = 1'b1;
    tick();
    rtr_if.err = 1'b0;
    chk("err_set", {31'd0, err_seen}, 32'd1);
    request(2'd0, 6'd0, 1'b0);
    chk("err_clr", {31'd0, err_seen}, 32'd0);
    drain();

    // Request gating on buffered byte count
    for (int i = 0; i < 4; i++) write_byte(8'hA0 + 8'(i));
    req_valid = 1'b1; req_addr = 2'd2; req_len = 6'd5; req_bad_parity = 1'b0;
    #1 chk("gate_ready0", {31'd0, req_ready}, 32'd0);
    tick();
    pv_data("gate_nohdr", 9'h000);
    pay_wr_en = 1'b1; pay_data = 8'hA4;
    tick();
    pay_wr_en = 1'b0;
    #1 chk("gate_ready1", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    pv_data("gate_hdr", 9'h116);
    drain();

    // Buffer overflow: the 65th byte is dropped
    for (int i = 0; i < 65; i++) write_byte(8'(i));
    chk("ovf_full", {31'd0, pay_full}, 32'd1);
    chk("ovf_count", {25'd0, pay_count}, 32'd64);
    request(2'd0, 6'd63, 1'b0);
    drain();
    request(2'd3, 6'd1, 1'b0);
    pv_data("ovf_hdr", 9'h107);
    tick(); pv_data("ovf_last", 9'h13F);
    drain();
    chk("ovf_empty", {25'd0, pay_count}, 32'd0);

    // Reset mid-packet
    write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
    request(2'd1, 6'd3, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    pv_data("rst_bus", 9'h000);
    chk("rst_count", {25'd0, pay_count}, 32'd0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    request(2'd2, 6'd0, 1'b0);
    pv_data("rst_hdr", 9'h102);
    tick(); pv_data("rst_par", 9'h002);
    drain();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      pay_wr_en      = ($urandom_range(0, 99) < 55);
      pay_data       = 8'($urandom);
      rtr_if.busy    = ($urandom_range(0, 99) < 25);
      rtr_if.err     = ($urandom_range(0, 99) < 3);
      req_valid      = ($urandom_range(0, 99) < 40);
      req_addr       = 2'($urandom);
      req_len        = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 6));
      req_bad_parity = ($urandom_range(0, 3) == 0);
      tick();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet transmitter that drives the router's input side (`packet_valid`, `data`, `busy`). It formats a packet from a request (destination address, payload length) and a buffered payload: header byte, payload bytes, then parity byte. It stalls on `busy` and returns to idle after a programmable gap. It sits upstream of the router as the source end of the router input protocol.

## Interface
- `DEPTH`, 64: payload buffer depth in bytes. Must be at least 63, the maximum packet payload.
- `GAP`, 1: number of idle cycles, with `packet_valid` low, after the parity byte is consumed.

- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `pay_wr_en` in 1: write `pay_data` into the payload buffer.
- `pay_data` in 8: payload byte.
- `pay_full` out 1: the buffer holds `DEPTH` bytes.
- `pay_count` out 7: number of bytes currently buffered.
- `req_valid` in 1: a packet request is present.
- `req_addr` in 2: destination port. Sent unchanged; 3 is permitted for negative tests.
- `req_len` in 6: payload length, 0–63.
- `req_bad_parity` in 1: invert the parity byte for this packet.
- `req_ready` out 1: combinational; `state==IDLE && pay_count >= req_len`.
- `busy` in 1: router busy. A byte is consumed only at an edge where `busy==0`.
- `err` in 1: router parity-error flag.
- `packet_valid` out 1: registered; drives the router `packet_valid` input.
- `data` out 8: registered; drives the router `data` input.
- `tx_done` out 1: one-cycle pulse when a packet is complete.
- `err_seen` out 1: sticky flag, set when `err` is sampled high.

## Operation
- **Header format:** `{req_len, req_addr}`. The length occupies bits 7:2 and the address bits 1:0.
- **Parity:** XOR of the header and all payload bytes. It is inverted (`~`) when `req_bad_parity` was latched at accept.
- **Accept:** at an edge where `req_valid && req_ready`, the block latches the address, length and bad-parity bit.
- **State machine, IDLE:**
  - On accept, `data`←header, `packet_valid`←1, parity accumulator←header, go to HEADER.
- **HEADER, at an edge with `busy==0`:**
  - If `len>0`: pop the buffer head into `data`, keep `packet_valid` at 1, go to PAYLOAD with `remaining`=`len`.
  - Otherwise: `data`←parity, `packet_valid`←0, go to PARITY.
- **PAYLOAD, at an edge with `busy==0`:**
  - If `remaining>1`: pop the next byte into `data` and decrement `remaining`.
  - Otherwise: `data`←parity, `packet_valid`←0, go to PARITY.
  - Each popped byte is XORed into the accumulator.
- **PARITY, at an edge with `busy==0`:**
  - `data`←0, `tx_done`←1 for one cycle.
  - Go to GAP and load the gap counter with `GAP`, or go straight to IDLE if `GAP==0`.
- **GAP:** counts down; enters IDLE when the counter reaches 1.
- **Busy stall:** while `busy==1`, `data`, `packet_valid` and the state hold, and no pop occurs.
- **Payload buffer:**
  - First-word-fall-through.
  - A write while full is dropped, even if a pop occurs in the same cycle.
  - A simultaneous write and pop leaves `pay_count` unchanged.
  - Writes are accepted in any state.
- **`err_seen`:**
  - Set at any edge where `err==1`.
  - Cleared at accept.
  - If set and clear occur in the same cycle, set wins.

## Timing
- **Reset values:** `packet_valid`=0, `data`=0, `tx_done`=0, `err_seen`=0, `pay_count`=0, `pay_full`=0, state=IDLE.
- **Reset mid-packet:** the packet is abandoned and the buffer is emptied.
- **Header latency:** the header appears on `data` one cycle after the accept edge.
- **Packet duration:** with `busy` always low, a packet occupies `len+2` cycles on `data`:
  - `len+1` cycles with `packet_valid` high (header and payload);
  - 1 parity cycle with `packet_valid` low.
- **`tx_done`:** asserted in the cycle after the parity byte is consumed.
- **Back-to-back packets:** the next header appears no earlier than `GAP+1` cycles after `tx_done`.
- **Request timing:** `req_ready` may change in the same cycle as `req_len` changes. Requests are never accepted outside IDLE.

## Structure
- **Package `router_tx_pkg`:**
  - state encodings (IDLE, HEADER, PAYLOAD, PARITY, GAP);
  - header field positions: `ADDR_LSB`=0, `ADDR_W`=2, `LEN_LSB`=2, `LEN_W`=6;
  - `MAX_LEN`=63.
- **Sub-module `router_tx_fifo`:** payload buffer (`DEPTH`×8, first-word-fall-through, count/full outputs).
- **Top level `router_pkt_tx`:** holds the state machine, the `remaining` counter, the gap counter, the parity accumulator and the output registers.

## Test plan
- **Basic 3-byte packet:** write 0x11, 0x22, 0x33; request addr=1, len=3, `busy`=0 → `data` shows 0x0D, 0x11, 0x22, 0x33 with `packet_valid`=1, then 0x0D with `packet_valid`=0. `tx_done` pulses the next cycle and `pay_count` returns to 0.
- **Busy stall on header:** same packet with `busy`=1 for 3 cycles after the header appears → 0x0D is held for 4 cycles, `pay_count` stays 3, then the sequence resumes unchanged.
- **Request gating:** req len=5 with 4 bytes buffered → `req_ready`=0 and no header appears. After the 5th write, `req_ready`=1 and the header 0x14|addr appears the next cycle.
- **Bad parity:** packet from the basic test with `req_bad_parity`=1 → parity byte is 0xF2. Driving `err`=1 afterwards sets `err_seen`, which clears on the next accept.
- **Buffer overflow:** 65 writes with no request → `pay_full`=1, `pay_count`=64, the 65th byte is absent from the later payload.
- **Reset mid-packet:** assert `reset` during the PAYLOAD state → `packet_valid`=0, `data`=0 and `pay_count`=0 immediately. After release, a len=0 request to addr 2 produces 0x02 followed by parity 0x02.
